// File: rtl/spi_reg_writer.sv
// SPI Mode 0 master that sends register writes as [address][data] frames to the synth.
// Optional feature: define SPI_REG_WRITER_BURST_EN to continue sequential-address writes in one CS window.
module spi_reg_writer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_done,
  output logic       spi_mosi,
  output logic       spi_sck,
  output logic       spi_cs
);

  localparam int PW = $clog2(CLK_DIV);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] HIGH  = 3'd2;
  localparam logic [2:0] LOW   = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;
  localparam logic [2:0] GAP   = 3'd5;

  generate
    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
      $error("spi_reg_writer: CLK_DIV must be in 2..255");
    end
  endgenerate

  logic [2:0]    state;
  logic [PW-1:0] phase;
  logic [3:0]    bit_cnt;
  logic [15:0]   shift;
  logic          phase_last;

  assign phase_last = (phase == PW'(CLK_DIV - 1));
  assign busy       = (state != IDLE);
  // MOSI comes straight off the shift register flop, so it moves exactly when the bits shift.
  assign spi_mosi   = shift[15];

`ifdef SPI_REG_WRITER_BURST_EN
  logic [7:0] addr_q;
  logic       burst_ok;

  // The slave auto-increments, so only the next sequential address may ride the open CS window.
  assign burst_ok = (state == HOLD) && (wr_addr == addr_q + 8'd1);
  assign wr_ready = !rst && ((state == IDLE) || burst_ok);
`else
  assign wr_ready = !rst && (state == IDLE);
`endif

  // The final SCK low phase doubles as the CS hold time, so HIGH of bit 15 goes straight to HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      spi_sck    <= 1'b0;
      spi_cs     <= 1'b1;
      frame_done <= 1'b0;
`ifdef SPI_REG_WRITER_BURST_EN
      addr_q     <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE || phase_last) phase <= '0;
      else                             phase <= phase + PW'(1);

      case (state)
        IDLE: begin
          if (wr_valid) begin
            shift   <= {wr_addr, wr_data};
            bit_cnt <= 4'd0;
            spi_cs  <= 1'b0;
            state   <= SETUP;
`ifdef SPI_REG_WRITER_BURST_EN
            addr_q  <= wr_addr;
`endif
          end
        end
        SETUP, LOW: begin
          if (phase_last) begin
            spi_sck <= 1'b1;
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (phase_last) begin
            spi_sck <= 1'b0;
            shift   <= {shift[14:0], 1'b0};
            if (bit_cnt == 4'd15) begin
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              state   <= LOW;
            end
          end
        end
        HOLD: begin
`ifdef SPI_REG_WRITER_BURST_EN
          if (wr_valid && burst_ok) begin
            shift   <= {wr_data, 8'h00};
            addr_q  <= addr_q + 8'd1;
            bit_cnt <= 4'd8;
            phase   <= '0;
            state   <= SETUP;
          end else
`endif
          if (phase_last) begin
            spi_cs     <= 1'b1;
            frame_done <= 1'b1;
            state      <= GAP;
          end
        end
        GAP: begin
          if (phase_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Self-checking bench for spi_reg_writer at CLK_DIV=4: frame contents, frame timing, reset abort and burst.
module tb_spi_reg_writer;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       frame_done;
  logic       spi_mosi;
  logic       spi_sck;
  logic       spi_cs;

  spi_reg_writer #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .spi_mosi   (spi_mosi),
    .spi_sck    (spi_sck),
    .spi_cs     (spi_cs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_word;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   acc_q[$];
  int   fd_cnt = 0;
  int   fd_cyc = -1;
  int   cs_low_cnt = 0;
  int   rdy_rise = -1;
  int   first_rise = -1;
  int   last_fall = -1;
  int   ready_busy = 0;
  int   hi_run = 0;
  int   min_gap = 1000;
  bit   seen_low = 0;
  logic prev_ready = 1'b0;
  logic prev_sck = 1'b0;
  logic bits[$];

  always @(posedge clk) cyc++;

  // The slave samples MOSI on SCK rising edges while CS is low.
  always @(posedge spi_sck) if (spi_cs === 1'b0) bits.push_back(spi_mosi);

  // Mid-cycle monitor: cycle n is the period just after clock edge n.
  always @(negedge clk) begin
    #2;
    if (wr_valid && wr_ready) begin
      acc_cnt++;
      acc_q.push_back(cyc);
    end
    if (spi_cs === 1'b0) cs_low_cnt++;
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (wr_ready && !prev_ready) rdy_rise = cyc;
    if (spi_sck && !prev_sck && first_rise < 0) first_rise = cyc;
    if (!spi_sck && prev_sck) last_fall = cyc;
    if (wr_ready && busy) ready_busy++;
    if (spi_cs) hi_run++;
    else begin
      if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
      seen_low = 1;
    end
    prev_ready = wr_ready;
    prev_sck   = spi_sck;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic clearMon();
    acc_q.delete();
    bits.delete();
    fd_cnt = 0;
    cs_low_cnt = 0;
    first_rise = -1;
    last_fall = -1;
    ready_busy = 0;
    hi_run = 0;
    min_gap = 1000;
    seen_low = 0;
  endtask

  // Presents one request and returns just after its capture edge; keep leaves wr_valid high.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input bit keep);
    int old;
    bit got;
    old = acc_cnt;
    got = 0;
    @(negedge clk);
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    for (int i = 0; i < 3000 && !got; i++) begin
      #3;
      if (acc_cnt != old) got = 1;
      else @(negedge clk);
    end
    if (!got) checkOutput("handshake timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!keep) begin
      wr_valid = 1'b0;
      wr_addr  = 8'($urandom);
      wr_data  = 8'($urandom);
    end
  endtask

  task automatic waitFrames(input int n);
    bit done;
    done = 0;
    for (int i = 0; i < 10000 && !done; i++) begin
      @(negedge clk);
      #3;
      if (fd_cnt >= n && !busy) done = 1;
    end
    repeat (3) @(negedge clk);
    checkOutput("frame_done count", fd_cnt, n);
  endtask

  function automatic logic [15:0] wordAt(input int base);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = (base + i < bits.size()) ? bits[base+i] : 1'bx;
    return w;
  endfunction

  function automatic logic [7:0] byteAt(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = (base + i < bits.size()) ? bits[base+i] : 1'bx;
    return b;
  endfunction

  initial begin
    vec_t vecs[4];
    int   t;
    bit   reached;

    vecs[0] = '{8'h05, 8'h80, 16'h0580};
    vecs[1] = '{8'h00, 8'h1C, 16'h001C};
    vecs[2] = '{8'h06, 8'hFF, 16'h06FF};
    vecs[3] = '{8'hA5, 8'h3C, 16'hA53C};

    rst = 1'b1;
    wr_valid = 1'b0;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    #3;
    checkOutput("reset spi_cs", spi_cs, 1);
    checkOutput("reset spi_sck", spi_sck, 0);
    checkOutput("reset spi_mosi", spi_mosi, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset frame_done", frame_done, 0);
    checkOutput("wr_ready during reset", wr_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    checkOutput("wr_ready after reset", wr_ready, 1);

    // Single frames with full timing checks relative to the accept cycle T.
    for (int v = 0; v < 4; v++) begin
      clearMon();
      applyStimulus(vecs[v].addr, vecs[v].data, 0);
      t = acc_q[0];
      waitFrames(1);
      checkOutput("frame word", wordAt(0), vecs[v].exp_word);
      checkOutput("sck rising edges", bits.size(), 16);
      checkOutput("cs low cycles", cs_low_cnt, 132);
      checkOutput("first sck rise offset", first_rise - t, 5);
      checkOutput("last sck fall offset", last_fall - t, 129);
      checkOutput("frame_done offset", fd_cyc - t, 133);
      checkOutput("wr_ready return offset", rdy_rise - t, 137);
    end

    // Back-to-back with wr_valid held across both requests.
    clearMon();
    applyStimulus(8'h00, 8'h1C, 1);
    applyStimulus(8'h06, 8'hFF, 0);
    checkOutput("second accept on ready rise", acc_q[1], rdy_rise);
    checkOutput("accept spacing", acc_q[1] - acc_q[0], 137);
    waitFrames(2);
    checkOutput("b2b word 0", wordAt(0), 16'h001C);
    checkOutput("b2b word 1", wordAt(16), 16'h06FF);
    checkOutput("cs high gap >= 4", (min_gap >= 4), 1);

    // Reset while SCK is high for bit 9 aborts the frame silently.
    clearMon();
    applyStimulus(8'h5A, 8'hC3, 0);
    reached = 0;
    for (int i = 0; i < 500 && !reached; i++) begin
      @(negedge clk);
      if (bits.size() >= 10) reached = 1;
    end
    checkOutput("bit 9 reached", reached, 1);
    checkOutput("sck high at abort", spi_sck, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort spi_cs", spi_cs, 1);
    checkOutput("abort spi_sck", spi_sck, 0);
    checkOutput("abort spi_mosi", spi_mosi, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort frame_done", frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("no frame_done after abort", fd_cnt, 0);
    clearMon();
    applyStimulus(8'h02, 8'hAA, 0);
    waitFrames(1);
    checkOutput("post-abort word", wordAt(0), 16'h02AA);

    // Sequential-address run: one window with burst, three frames without.
    clearMon();
    applyStimulus(8'h02, 8'h11, 1);
    applyStimulus(8'h03, 8'h22, 1);
    applyStimulus(8'h04, 8'h33, 0);
`ifdef SPI_REG_WRITER_BURST_EN
    waitFrames(1);
    checkOutput("burst sck edges", bits.size(), 32);
    checkOutput("burst byte 0", byteAt(0), 8'h02);
    checkOutput("burst byte 1", byteAt(8), 8'h11);
    checkOutput("burst byte 2", byteAt(16), 8'h22);
    checkOutput("burst byte 3", byteAt(24), 8'h33);
`else
    waitFrames(3);
    checkOutput("seq sck edges", bits.size(), 48);
    checkOutput("seq word 0", wordAt(0), 16'h0211);
    checkOutput("seq word 1", wordAt(16), 16'h0322);
    checkOutput("seq word 2", wordAt(32), 16'h0433);
`endif

    // A non-sequential address never gets wr_ready while a frame is open.
    clearMon();
    applyStimulus(8'h02, 8'h11, 1);
    applyStimulus(8'h06, 8'h40, 0);
    waitFrames(2);
    checkOutput("ready while busy", ready_busy, 0);
    checkOutput("nonseq word 0", wordAt(0), 16'h0211);
    checkOutput("nonseq word 1", wordAt(16), 16'h0640);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
